// File: rtl/exp2_pkg.sv
// exp2_pkg: shared types and constants for the exp2 antilog unit.
//   state_e         - engine state encoding (IDLE, CALC, ROUND, DONE)
//   EXP2_FRAC_BITS  - fractional bits of the Q3.5 log2 input
//   EXP2_MANT_WIDTH - width of the unsigned Q1.15 mantissa
//   MANT_ONE        - 1.0 in Q1.15
//   RND_OFFSET      - 0.5 LSB offset used when dropping 15 product bits
//   EXP2_C          - 2^(2^-(i+1)) in Q1.15, rounded to nearest
`timescale 1ns/1ps
package exp2_pkg;

   localparam int unsigned EXP2_FRAC_BITS  = 5;
   localparam int unsigned EXP2_MANT_WIDTH = 16;

   localparam logic [EXP2_MANT_WIDTH-1:0]   MANT_ONE   = 16'h8000;
   localparam logic [2*EXP2_MANT_WIDTH-1:0] RND_OFFSET = 32'd16384;

   typedef enum logic [1:0] {
      IDLE,
      CALC,
      ROUND,
      DONE
   } state_e;

   // Index 0 is applied for the most significant fractional bit.
   localparam logic [EXP2_MANT_WIDTH-1:0] EXP2_C [0:EXP2_FRAC_BITS-1] = '{
      16'd46341,  // 2^(1/2)
      16'd38968,  // 2^(1/4)
      16'd35733,  // 2^(1/8)
      16'd34219,  // 2^(1/16)
      16'd33486   // 2^(1/32)
   };

endpackage

// File: rtl/exp2_q15_mul_rnd.sv
// q15_mul_rnd: combinational unsigned Q1.15 x Q1.15 multiply.
//   a_i [MANT_WIDTH] - multiplicand, Q1.15
//   b_i [MANT_WIDTH] - multiplier, Q1.15
//   p_o [MANT_WIDTH] - (a_i * b_i + 2^14) >> 15, low MANT_WIDTH bits
`timescale 1ns/1ps
module q15_mul_rnd
   import exp2_pkg::*;
#(
   parameter int unsigned MANT_WIDTH = EXP2_MANT_WIDTH
) (
   input  logic [MANT_WIDTH-1:0] a_i,
   input  logic [MANT_WIDTH-1:0] b_i,
   output logic [MANT_WIDTH-1:0] p_o
);

   localparam int unsigned PW = 2 * MANT_WIDTH;

   logic [PW-1:0] prod_w;
   logic [PW-1:0] sum_w;
   logic          unused_bits_w;

   assign prod_w = {{MANT_WIDTH{1'b0}}, a_i} * {{MANT_WIDTH{1'b0}}, b_i};

   // Full-width product plus half an output LSB cannot wrap 2*MANT_WIDTH bits.
   assign sum_w  = prod_w + (PW'(1) << (MANT_WIDTH - 2));

   assign p_o    = sum_w[PW-2 -: MANT_WIDTH];

   assign unused_bits_w = ^{sum_w[PW-1], sum_w[MANT_WIDTH-2:0]};

endmodule

// File: rtl/exp2.sv
// exp2: iterative fixed-point antilog, number_o = round(2^number_i).
//   clk_i    - clock, rising edge
//   rstn_i   - synchronous active-low reset
//   valid_i  - number_i is valid
//   ready_o  - block can accept an input (state == IDLE)
//   number_i - log2 value, unsigned Q3.5
//   valid_o  - number_o holds a result
//   ready_i  - downstream accepts the result
//   number_o - rounded 2^number_i, unsigned integer
// One fractional bit is folded into the mantissa per CALC cycle, MSB first;
// the integer part is applied at ROUND as a rounding right shift.
`timescale 1ns/1ps
module exp2
   import exp2_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned FRAC_BITS  = EXP2_FRAC_BITS,
   parameter int unsigned MANT_WIDTH = EXP2_MANT_WIDTH
) (
   input  logic                  clk_i,
   input  logic                  rstn_i,
   input  logic                  valid_i,
   output logic                  ready_o,
   input  logic [DATA_WIDTH-1:0] number_i,
   output logic                  valid_o,
   input  logic                  ready_i,
   output logic [DATA_WIDTH-1:0] number_o
);

   localparam int unsigned INT_BITS = DATA_WIDTH - FRAC_BITS;
   localparam int unsigned JW       = $clog2(FRAC_BITS);
   localparam int unsigned SW       = $clog2(MANT_WIDTH);
   localparam int unsigned RW       = MANT_WIDTH + 1;
   localparam logic [JW-1:0] JMAX   = JW'(FRAC_BITS - 1);

   state_e                  state_q, state_d;
   logic [INT_BITS-1:0]     int_q, int_d;
   logic [FRAC_BITS-1:0]    frac_q, frac_d;
   logic [MANT_WIDTH-1:0]   m_q, m_d;
   logic [JW-1:0]           j_q, j_d;
   logic [DATA_WIDTH-1:0]   num_q, num_d;
   logic                    valid_q, valid_d;

   logic [JW-1:0]           cidx_w;
   logic [MANT_WIDTH-1:0]   coef_w;
   logic [MANT_WIDTH-1:0]   mul_p_w;
   logic [SW-1:0]           sh_w;
   logic [RW-1:0]           rnd_off_w;
   logic [RW-1:0]           rnd_w;
   logic                    unused_rnd_w;

   // Single shared multiplier; its coefficient follows the bit being folded.
   assign cidx_w = JMAX - j_q;
   assign coef_w = EXP2_C[cidx_w];

   q15_mul_rnd #(
      .MANT_WIDTH(MANT_WIDTH)
   ) u_mul (
      .a_i(m_q),
      .b_i(coef_w),
      .p_o(mul_p_w)
   );

   // Result = m * 2^int in Q1.15, so drop (15 - int) bits with half-LSB rounding.
   assign sh_w      = SW'(MANT_WIDTH - 1) - SW'(int_q);
   assign rnd_off_w = RW'(1) << (sh_w - SW'(1));
   assign rnd_w     = ({1'b0, m_q} + rnd_off_w) >> sh_w;

   assign unused_rnd_w = ^rnd_w[RW-1:DATA_WIDTH];

   assign ready_o  = (state_q == IDLE);
   assign valid_o  = valid_q;
   assign number_o = num_q;

   always_comb begin
      state_d = state_q;
      int_d   = int_q;
      frac_d  = frac_q;
      m_d     = m_q;
      j_d     = j_q;
      num_d   = num_q;
      valid_d = valid_q;
      unique case (state_q)
         IDLE: begin
            if (valid_i && ready_o) begin
               int_d   = number_i[DATA_WIDTH-1:FRAC_BITS];
               frac_d  = number_i[FRAC_BITS-1:0];
               m_d     = MANT_ONE;
               j_d     = JMAX;
               state_d = CALC;
            end
         end
         CALC: begin
            if (frac_q[j_q]) begin
               m_d = mul_p_w;
            end
            if (j_q == '0) begin
               state_d = ROUND;
            end else begin
               j_d = j_q - JW'(1);
            end
         end
         ROUND: begin
            num_d   = rnd_w[DATA_WIDTH-1:0];
            valid_d = 1'b1;
            state_d = DONE;
         end
         DONE: begin
            if (ready_i) begin
               valid_d = 1'b0;
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (!rstn_i) begin
         state_q <= IDLE;
         int_q   <= '0;
         frac_q  <= '0;
         m_q     <= MANT_ONE;
         j_q     <= '0;
         num_q   <= '0;
         valid_q <= 1'b0;
      end else begin
         state_q <= state_d;
         int_q   <= int_d;
         frac_q  <= frac_d;
         m_q     <= m_d;
         j_q     <= j_d;
         num_q   <= num_d;
         valid_q <= valid_d;
      end
   end

   a_result_in_range: assert property (
      @(posedge clk_i) disable iff (!rstn_i)
      (state_q == ROUND) |-> (rnd_w[RW-1:DATA_WIDTH] == '0)
   );

endmodule

// File: tb/tb_exp2.sv
`timescale 1ns/1ps
module tb_exp2;

   logic       clk;
   logic       rstn;
   logic       valid_i;
   logic       ready_o;
   logic [7:0] number_i;
   logic       valid_o;
   logic       ready_i;
   logic [7:0] number_o;

   logic [15:0] ma, mb, mp;

   int checks = 0;
   int errors = 0;

   exp2 #(
      .DATA_WIDTH(8),
      .FRAC_BITS(5),
      .MANT_WIDTH(16)
   ) dut (
      .clk_i(clk),
      .rstn_i(rstn),
      .valid_i(valid_i),
      .ready_o(ready_o),
      .number_i(number_i),
      .valid_o(valid_o),
      .ready_i(ready_i),
      .number_o(number_o)
   );

   q15_mul_rnd #(
      .MANT_WIDTH(16)
   ) u_mul_ut (
      .a_i(ma),
      .b_i(mb),
      .p_o(mp)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
      $fatal(1);
   end

   typedef struct {
      string       name;
      logic [7:0]  num;
      logic [7:0]  exp;
   } vec_t;

   typedef struct {
      logic [15:0] a;
      logic [15:0] b;
      logic [15:0] p;
   } mvec_t;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Independent reference: 2^frac by successive Q1.15 roots, then 2^int shift.
   function automatic int unsigned model(input int unsigned x);
      longint unsigned m = 32768;
      longint unsigned k[5] = '{46341, 38968, 35733, 34219, 33486};
      int unsigned ip;
      for (int b = 4; b >= 0; b--) begin
         if (((x >> b) & 1) == 1) m = (m * k[4 - b] + 64'd16384) >> 15;
      end
      ip = x >> 5;
      return int'((m + (64'd1 << (14 - ip))) >> (15 - ip));
   endfunction

   // Presents x at a negedge while IDLE; returns result and edges from accept to valid_o.
   task automatic run_txn(input logic [7:0] x, output logic [7:0] y, output int edges);
      chk("ready_before_accept", ready_o, 1);
      number_i = x;
      valid_i  = 1'b1;
      @(negedge clk);
      valid_i = 1'b0;
      chk("ready_drop_after_accept", ready_o, 0);
      edges = 0;
      while (!valid_o && edges < 30) begin
         @(negedge clk);
         edges++;
      end
      y = number_o;
   endtask

   initial begin
      vec_t  vecs[8];
      mvec_t mvecs[5];
      logic [7:0] y;
      int e;

      vecs[0] = '{"in_0x00", 8'h00, 8'd1};
      vecs[1] = '{"in_0x20", 8'h20, 8'd2};
      vecs[2] = '{"in_0x40", 8'h40, 8'd4};
      vecs[3] = '{"in_0xE0", 8'hE0, 8'd128};
      vecs[4] = '{"in_0x10", 8'h10, 8'd1};
      vecs[5] = '{"in_0x50", 8'h50, 8'd6};
      vecs[6] = '{"in_0x1F", 8'h1F, 8'd2};
      vecs[7] = '{"in_0xFF", 8'hFF, 8'd251};

      mvecs[0] = '{16'd32768, 16'd46341, 16'd46341};
      mvecs[1] = '{16'd46341, 16'd38968, 16'd55109};
      mvecs[2] = '{16'd55109, 16'd35733, 16'd60096};
      mvecs[3] = '{16'd1,     16'd16384, 16'd1};
      mvecs[4] = '{16'd1,     16'd16383, 16'd0};

      rstn = 1'b0; valid_i = 1'b0; ready_i = 1'b0; number_i = 8'h00;
      ma = '0; mb = '0;

      for (int i = 0; i < 5; i++) begin
         ma = mvecs[i].a;
         mb = mvecs[i].b;
         #1;
         chk($sformatf("mul_%0d_x_%0d", ma, mb), mp, mvecs[i].p);
      end

      repeat (3) @(negedge clk);
      chk("reset_valid_o", valid_o, 0);
      chk("reset_number_o", number_o, 0);
      chk("reset_ready_o", ready_o, 1);
      rstn = 1'b1;
      @(negedge clk);

      // Directed table, downstream always ready.
      ready_i = 1'b1;
      for (int i = 0; i < 8; i++) begin
         run_txn(vecs[i].num, y, e);
         chk({vecs[i].name, "_latency"}, e, 6);
         chk(vecs[i].name, y, vecs[i].exp);
         @(negedge clk);
         chk({vecs[i].name, "_valid_clear"}, valid_o, 0);
         chk({vecs[i].name, "_ready_back"}, ready_o, 1);
      end

      // Backpressure: result held for 20 cycles.
      ready_i = 1'b0;
      run_txn(8'h40, y, e);
      chk("bp_latency", e, 6);
      chk("bp_value", y, 4);
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         chk("bp_hold_valid", valid_o, 1);
         chk("bp_hold_number", number_o, 4);
         chk("bp_hold_ready", ready_o, 0);
      end
      ready_i = 1'b1;
      @(negedge clk);
      chk("bp_release_valid", valid_o, 0);
      chk("bp_release_ready", ready_o, 1);
      chk("bp_release_number", number_o, 4);

      // Exhaustive sweep: valid_i held high with junk on number_i while busy,
      // so each accept must land exactly 8 cycles after the previous one.
      for (int i = 0; i < 256; i++) begin
         int unsigned exp_v;
         int unsigned ideal;
         int diff;
         chk("sweep_ready_on_slot", ready_o, 1);
         number_i = 8'(i);
         valid_i  = 1'b1;
         for (int c = 1; c <= 7; c++) begin
            @(negedge clk);
            if (c == 6) chk("sweep_valid_not_early", valid_o, 0);
            if (c == 7) begin
               exp_v = model(i);
               chk($sformatf("sweep_valid_%0d", i), valid_o, 1);
               chk($sformatf("sweep_value_%0d", i), number_o, exp_v);
               ideal = int'($rtoi(2.0 ** (real'(i) / 32.0) + 0.5));
               diff  = int'(number_o) - int'(ideal);
               checks++;
               if (diff > 1 || diff < -1) begin
                  errors++;
                  $display("FAIL sweep_approx_%0d: got %0d expected %0d +-1", i, number_o, ideal);
               end
            end
            number_i = 8'($urandom);
         end
         @(negedge clk);
      end
      valid_i = 1'b0;

      // Reset during CALC discards the pending result.
      number_i = 8'hE0;
      valid_i  = 1'b1;
      @(negedge clk);
      valid_i = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rstn = 1'b0;
      @(negedge clk);
      chk("midrst_valid_o", valid_o, 0);
      chk("midrst_number_o", number_o, 0);
      chk("midrst_ready_o", ready_o, 1);
      rstn = 1'b1;
      for (int c = 0; c < 12; c++) begin
         @(negedge clk);
         chk("midrst_no_stray_valid", valid_o, 0);
      end
      run_txn(8'hFF, y, e);
      chk("midrst_next_latency", e, 6);
      chk("midrst_next_value", y, 251);
      @(negedge clk);
      chk("midrst_next_ready", ready_o, 1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
